// File: rtl/jt08_adpcmb_pkg.sv
// jt08_adpcmb_pkg: shared constants, step factor table and FSM states for the ADPCM-B decoder
package jt08_adpcmb_pkg;
  localparam int STEP_INIT_D = 127;
  localparam int STEP_MIN_D  = 127;
  localparam int STEP_MAX_D  = 24576;
  typedef enum logic [1:0] {IDLE, MUL_D, MUL_S, COMMIT} state_t;
  function automatic logic [7:0] f_factor(input logic [2:0] mag);
    case (mag)
      3'd4:    return 8'd77;
      3'd5:    return 8'd102;
      3'd6:    return 8'd128;
      3'd7:    return 8'd153;
      default: return 8'd57;
    endcase
  endfunction
endpackage

// File: rtl/jt08_adpcmb_smul.sv
// jt08_adpcmb_smul: serial shift-add multiplier, one multiplier bit per clk
// start consumes bit 0; done flags the edge that adds the last bit.
module jt08_adpcmb_smul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        start,
  input  logic [3:0]  nbits,
  input  logic [7:0]  mult,
  input  logic [15:0] mcand,
  output logic [21:0] acc,
  output logic        done
);
  logic [7:0]  m;
  logic [3:0]  cnt;
  logic        run;
  logic [21:0] term;
  assign term = m[0] ? {6'd0, mcand} << cnt : '0;
  assign done = run && cnt == nbits - 4'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      m   <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      m   <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      acc <= mult[0] ? {6'd0, mcand} : '0;
      m   <= mult >> 1;
      cnt <= 4'd1;
      run <= 1'b1;
    end else if (run) begin
      acc <= acc + term;
      m   <= m >> 1;
      cnt <= cnt + 4'd1;
      run <= !done;
    end
endmodule

// File: rtl/jt08_adpcmb_dec.sv
// jt08_adpcmb_dec: ADPCM-B delta-T nibble decoder built around one shared serial multiplier
module jt08_adpcmb_dec
  import jt08_adpcmb_pkg::*;
#(
  parameter int STEP_INIT = STEP_INIT_D,
  parameter int STEP_MIN  = STEP_MIN_D,
  parameter int STEP_MAX  = STEP_MAX_D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cen,
  input  logic               adv,
  input  logic               clr,
  input  logic [7:0]         data,
  input  logic               nibble_sel,
  output logic signed [15:0] pcm,
  output logic               pcm_ok,
  output logic               busy,
  output logic               ovr
);
  localparam logic [21:0] S_MIN = 22'(STEP_MIN);
  localparam logic [21:0] S_MAX = 22'(STEP_MAX);
  state_t             st;
  logic [3:0]         nib;
  logic               go;
  logic [18:0]        dacc;
  logic [15:0]        step, diff, s_new;
  logic [21:0]        acc, s_sh;
  logic               done;
  logic signed [17:0] xs;
  logic signed [15:0] x_new;
  jt08_adpcmb_smul u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .start (go),
    .nbits (st == MUL_D ? 4'd4 : 4'd8),
    .mult  (st == MUL_D ? {4'd0, nib[2:0], 1'b1} : f_factor(nib[2:0])),
    .mcand (step),
    .acc   (acc),
    .done  (done)
  );
  // pcm doubles as the predictor x; both products derive from the pre-commit step
  assign diff  = 16'(dacc >> 3);
  assign xs    = nib[3] ? {{2{pcm[15]}}, pcm} - {2'b0, diff} : {{2{pcm[15]}}, pcm} + {2'b0, diff};
  assign x_new = xs < -18'sd32768 ? 16'sh8000 : xs > 18'sd32767 ? 16'sh7fff : xs[15:0];
  assign s_sh  = acc >> 6;
  assign s_new = s_sh < S_MIN ? S_MIN[15:0] : s_sh > S_MAX ? S_MAX[15:0] : s_sh[15:0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st     <= IDLE;
      nib    <= '0;
      go     <= 1'b0;
      dacc   <= '0;
      step   <= 16'(STEP_INIT);
      pcm    <= '0;
      pcm_ok <= 1'b0;
      busy   <= 1'b0;
      ovr    <= 1'b0;
    end else if (clr) begin
      st     <= IDLE;
      go     <= 1'b0;
      dacc   <= '0;
      step   <= 16'(STEP_INIT);
      pcm    <= '0;
      pcm_ok <= 1'b0;
      busy   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      pcm_ok <= 1'b0;
      go     <= 1'b0;
      if (cen && adv && st != IDLE) ovr <= 1'b1;
      case (st)
        IDLE: if (cen && adv) begin
          nib  <= nibble_sel ? data[3:0] : data[7:4];
          busy <= 1'b1;
          go   <= 1'b1;
          st   <= MUL_D;
        end
        MUL_D: if (done) begin
          go <= 1'b1;
          st <= MUL_S;
        end
        MUL_S: begin
          if (go) dacc <= acc[18:0];
          if (done) st <= COMMIT;
        end
        COMMIT: begin
          pcm    <= x_new;
          step   <= s_new;
          pcm_ok <= 1'b1;
          busy   <= 1'b0;
          st     <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_jt08_adpcmb_dec.sv
// tb_jt08_adpcmb_dec: randomized scoreboard bench against an arithmetic delta-T reference model
module tb_jt08_adpcmb_dec;
  logic clk = 1'b0, rst_n = 1'b0, cen = 1'b0, adv = 1'b0, clr = 1'b0, nibble_sel = 1'b0;
  logic [7:0] data = '0;
  logic signed [15:0] pcm;
  logic pcm_ok, busy, ovr;
  typedef struct {int val; int at;} exp_t;
  exp_t q[$];
  int ff[8] = '{57, 57, 57, 57, 77, 102, 128, 153};
  int edges = 0, total = 0, passed = 0;
  int mx = 0, mstep = 127, last_acc = -100;
  bit movr = 0;

  jt08_adpcmb_dec dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .adv(adv), .clr(clr), .data(data),
    .nibble_sel(nibble_sel), .pcm(pcm), .pcm_ok(pcm_ok), .busy(busy), .ovr(ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  function automatic int clamp(input int v, input int lo, input int hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    mx = 0; mstep = 127; movr = 0; last_acc = -100;
    q.delete();
  endtask

  task automatic tick(input bit c, input bit a, input bit k, input logic [7:0] d, input bit s);
    int n, mag, dif;
    exp_t e;
    cen = c; adv = a; clr = k; data = d; nibble_sel = s;
    @(posedge clk); #1;
    if (k) model_reset();
    else if (c && a) begin
      if (edges - last_acc >= 14) begin
        n = s ? int'(d[3:0]) : int'(d[7:4]);
        mag = n % 8;
        dif = mstep * (2 * mag + 1) / 8;
        mx = clamp(n >= 8 ? mx - dif : mx + dif, -32768, 32767);
        mstep = clamp(mstep * ff[mag] / 64, 127, 24576);
        e.val = mx; e.at = edges + 13;
        q.push_back(e);
        last_acc = edges;
      end else movr = 1;
    end
    cen = 0; adv = 0; clr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 8'h00, 0);
  endtask

  task automatic decode(input logic [7:0] d, input bit s);
    tick(1, 1, 0, d, s);
    idle(15);
  endtask

  task automatic do_reset();
    rst_n = 0; #3; rst_n = 1;
    model_reset();
  endtask

  always @(negedge clk) if (rst_n && pcm_ok) begin
    exp_t e;
    if (q.size() == 0) chk("unexpected_pcm_ok", 1, 0);
    else begin
      e = q.pop_front();
      chk("pcm", int'(pcm), e.val);
      chk("latency_edge", edges, e.at);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 rst_n = 1;
    @(posedge clk); #1;
    chk("rst_pcm", int'(pcm), 0);
    chk("rst_pcm_ok", pcm_ok, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    // 0x78 high nibble: +238, then a zero nibble exposes step=303 (diff 37)
    tick(1, 1, 0, 8'h78, 0);
    chk("busy_after_accept", busy, 1);
    idle(12);
    chk("busy_at_e12", busy, 1);
    idle(1);
    chk("busy_after_commit", busy, 0);
    chk("pcm_238", int'(pcm), 238);
    idle(2);
    decode(8'h00, 0);
    chk("pcm_after_step303", int'(pcm), 275);
    do_reset();
    decode(8'h78, 1);
    chk("pcm_neg15", int'(pcm), -15);
    decode(8'h00, 0);
    chk("pcm_step_clamped", int'(pcm), 0);
    repeat (200) decode(8'h77, $urandom_range(0, 1));
    chk("sat_pos", int'(pcm), 32767);
    repeat (200) decode(8'hFF, $urandom_range(0, 1));
    chk("sat_neg", int'(pcm), -32768);
    // clear mid-computation
    tick(1, 0, 1, 8'h00, 0);
    decode(8'h70, 0);
    tick(1, 1, 0, 8'h70, 0);
    idle(5);
    tick(0, 0, 1, 8'h00, 0);
    chk("clr_pcm", int'(pcm), 0);
    chk("clr_busy", busy, 0);
    idle(20);
    decode(8'h70, 0);
    chk("after_clr_238", int'(pcm), 238);
    // overrun with cen every 4 clk
    tick(1, 1, 0, 8'h70, 0); idle(3);
    tick(1, 1, 0, 8'h30, 0);
    chk("ovr_set", ovr, 1);
    idle(3);
    tick(1, 1, 0, 8'h30, 0);
    idle(16);
    chk("ovr_sticky", ovr, 1);
    chk("ovr_result", int'(pcm), mx);
    tick(0, 0, 1, 8'h00, 0);
    chk("ovr_cleared", ovr, 0);
    // counter off: clr and adv on the same cen edge
    tick(1, 1, 1, 8'h70, 0);
    chk("off_busy", busy, 0);
    idle(16);
    chk("off_pcm", int'(pcm), 0);
    // random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) tick($urandom_range(0, 1), $urandom_range(0, 1), 1, 8'($urandom), 0);
      tick(1, $urandom_range(0, 4) != 0, 0, 8'($urandom), $urandom_range(0, 1));
      chk("rand_ovr", ovr, movr);
      idle($urandom_range(0, 5) == 0 ? $urandom_range(2, 13) : $urandom_range(15, 19));
    end
    idle(20);
    chk("rand_pcm_final", int'(pcm), mx);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
